shared_port_arbiter: RTL and testbench



---
 rtl/shared_port_arbiter.sv | 103 ++++++++++
 tb/tb_shared_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter: shares one device port among NumHosts requesters; an in-order ID FIFO routes responses back.
// Define SHARED_PORT_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module shared_port_arbiter #(
   parameter int NumHosts       = 2,
   parameter int DataWidth      = 32,
   parameter int AddrWidth      = 20,
   parameter int MaxOutstanding = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NumHosts-1:0]               host_req_valid_i,
   output logic [NumHosts-1:0]               host_req_ready_o,
   input  logic [NumHosts*AddrWidth-1:0]     host_addr_i,
   input  logic [NumHosts-1:0]               host_wen_i,
   input  logic [NumHosts*DataWidth-1:0]     host_wdata_i,
   input  logic [NumHosts*DataWidth/8-1:0]   host_be_i,
   output logic [NumHosts-1:0]               host_resp_valid_o,
   input  logic [NumHosts-1:0]               host_resp_ready_i,
   output logic [DataWidth-1:0]              host_resp_rdata_o,
   output logic                              dev_req_valid_o,
   input  logic                              dev_req_ready_i,
   output logic [AddrWidth-1:0]              dev_addr_o,
   output logic                              dev_wen_o,
   output logic [DataWidth-1:0]              dev_wdata_o,
   output logic [DataWidth/8-1:0]            dev_be_o,
   input  logic                              dev_resp_valid_i,
   output logic                              dev_resp_ready_o,
   input  logic [DataWidth-1:0]              dev_resp_rdata_i,
   output logic                              err_o
);
   localparam int IW = $clog2(NumHosts);
   localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
   localparam int CW = $clog2(MaxOutstanding) + 1;
   localparam int BW = DataWidth / 8;
   logic [IW-1:0] ids [MaxOutstanding];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [IW-1:0] base, winner, head;
   logic [NumHosts-1:0] eligible;
   logic any, full, empty, push, pop, err;
   int j;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (int'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
   endfunction

   assign full     = count == CW'(MaxOutstanding);
   assign empty    = count == '0;
   assign eligible = host_req_valid_i & {NumHosts{!full}};

   // Scan downward so the first eligible host at or after base wins last.
   always_comb begin
      any = 1'b0;
      winner = '0;
      j = 0;
      for (int i = NumHosts - 1; i >= 0; i--) begin
         j = (int'(base) + i) % NumHosts;
         if (eligible[j]) begin
            any = 1'b1;
            winner = IW'(j);
         end
      end
   end

`ifdef SHARED_PORT_RR_EN
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) base <= '0;
      else if (push) base <= (int'(winner) == NumHosts - 1) ? '0 : winner + 1'b1;
`else
   assign base = '0;
`endif

   assign head = ids[rptr];
   assign push = any & dev_req_ready_i;
   assign pop  = dev_resp_valid_i & !empty & host_resp_ready_i[head];

   assign dev_req_valid_o   = any;
   assign dev_addr_o        = host_addr_i[winner*AddrWidth +: AddrWidth];
   assign dev_wen_o         = host_wen_i[winner];
   assign dev_wdata_o       = host_wdata_i[winner*DataWidth +: DataWidth];
   assign dev_be_o          = host_be_i[winner*BW +: BW];
   assign host_req_ready_o  = any ? NumHosts'(dev_req_ready_i) << winner : '0;
   assign host_resp_valid_o = empty ? '0 : NumHosts'(dev_resp_valid_i) << head;
   assign dev_resp_ready_o  = empty | host_resp_ready_i[head];
   assign host_resp_rdata_o = dev_resp_rdata_i;
   assign err_o             = err;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         err   <= 1'b0;
      end else begin
         if (push) wptr <= inc(wptr);
         if (pop) rptr <= inc(rptr);
         count <= count + CW'(push) - CW'(pop);
         if (dev_resp_valid_i && empty) err <= 1'b1;
      end

   always_ff @(posedge clk_i)
      if (push) ids[wptr] <= winner;
endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb_shared_port_arbiter: table vectors, hand-written corner sequences and a queue-based reference model.
module tb_shared_port_arbiter;
   localparam int N  = 2;
   localparam int AW = 20;
   localparam int DW = 32;
   localparam int MO = 2;
`ifdef SHARED_PORT_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid = '0, req_ready_o, resp_valid, resp_ready = '0, wen = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N*DW-1:0] wdata = '0;
   logic [N*DW/8-1:0] be = '0;
   logic [DW-1:0] resp_rdata, dev_wdata, rdata = '0;
   logic [AW-1:0] dev_addr;
   logic [DW/8-1:0] dev_be;
   logic dev_req_valid, dev_req_ready = 1'b0, dev_wen, dev_resp_valid = 1'b0, dev_resp_ready, err;

   int n_chk = 0;
   int n_fail = 0;
   int q[$];
   int rr = 0;
   bit merr = 1'b0;

   shared_port_arbiter #(.NumHosts(N), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .host_req_valid_i(req_valid), .host_req_ready_o(req_ready_o),
      .host_addr_i(addr), .host_wen_i(wen), .host_wdata_i(wdata), .host_be_i(be),
      .host_resp_valid_o(resp_valid), .host_resp_ready_i(resp_ready), .host_resp_rdata_o(resp_rdata),
      .dev_req_valid_o(dev_req_valid), .dev_req_ready_i(dev_req_ready),
      .dev_addr_o(dev_addr), .dev_wen_o(dev_wen), .dev_wdata_o(dev_wdata), .dev_be_o(dev_be),
      .dev_resp_valid_i(dev_resp_valid), .dev_resp_ready_o(dev_resp_ready),
      .dev_resp_rdata_i(rdata), .err_o(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rv; logic drdy; logic dv; logic [1:0] hrr; logic [31:0] rd;
      logic [1:0] rdy_rr; logic [1:0] rdy_fp; logic dval; logic [1:0] hval; logic drr; logic err;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pick(output bit any, output int w);
      any = 1'b0;
      w = 0;
      for (int k = N - 1; k >= 0; k--) begin
         int h;
         h = (rr + k) % N;
         if (req_valid[h] && q.size() < MO) begin
            any = 1'b1;
            w = h;
         end
      end
   endtask

   task automatic model_check();
      bit any;
      int w;
      logic [1:0] ehr, erv;
      logic edrr;
      pick(any, w);
      ehr = (any && dev_req_ready) ? 2'(1 << w) : 2'b00;
      chk("dev_req_valid", dev_req_valid, any);
      chk("host_req_ready", req_ready_o, ehr);
      if (any) begin
         chk("dev_addr", dev_addr, addr[w*AW +: AW]);
         chk("dev_wen", dev_wen, wen[w]);
         chk("dev_wdata", dev_wdata, wdata[w*DW +: DW]);
         chk("dev_be", dev_be, be[w*4 +: 4]);
      end
      if (q.size() > 0) begin
         erv = dev_resp_valid ? 2'(1 << q[0]) : 2'b00;
         edrr = resp_ready[q[0]];
      end else begin
         erv = 2'b00;
         edrr = 1'b1;
      end
      chk("host_resp_valid", resp_valid, erv);
      chk("dev_resp_ready", dev_resp_ready, edrr);
      chk("host_resp_rdata", resp_rdata, rdata);
      chk("err", err, merr);
   endtask

   task automatic model_update();
      bit any, pop;
      int w;
      pick(any, w);
      pop = dev_resp_valid && q.size() > 0 && resp_ready[q[0]];
      if (dev_resp_valid && q.size() == 0) merr = 1'b1;
      if (pop) void'(q.pop_front());
      if (any && dev_req_ready) begin
         q.push_back(w);
         if (RR) rr = (w + 1) % N;
      end
   endtask

   task automatic cycle_end();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step();
      #2;
      model_check();
      cycle_end();
   endtask

   task automatic model_reset();
      q.delete();
      rr = 0;
      merr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [1:0] rv, input logic drdy, input logic dv, input logic [1:0] hrr, input logic [31:0] rd);
      req_valid = rv;
      dev_req_ready = drdy;
      dev_resp_valid = dv;
      resp_ready = hrr;
      rdata = rd;
   endtask

   initial begin
      int g, gp;
      tbl[0]  = '{2'b01, 1'b1, 1'b0, 2'b11, 32'h0,        2'b01, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[1]  = '{2'b00, 1'b1, 1'b1, 2'b11, 32'hDEADBEEF, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[2]  = '{2'b10, 1'b1, 1'b0, 2'b11, 32'h0,        2'b10, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[3]  = '{2'b10, 1'b1, 1'b0, 2'b11, 32'h0,        2'b10, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[4]  = '{2'b11, 1'b1, 1'b0, 2'b11, 32'h0,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
      tbl[5]  = '{2'b11, 1'b1, 1'b1, 2'b11, 32'h11111111, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0};
      tbl[6]  = '{2'b11, 1'b1, 1'b0, 2'b11, 32'h0,        2'b01, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0};
      tbl[7]  = '{2'b00, 1'b1, 1'b1, 2'b01, 32'h22222222, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
      tbl[8]  = '{2'b00, 1'b1, 1'b1, 2'b01, 32'h22222222, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0};
      tbl[9]  = '{2'b00, 1'b1, 1'b1, 2'b11, 32'h33333333, 2'b00, 2'b00, 1'b0, 2'b10, 1'b1, 1'b0};
      tbl[10] = '{2'b00, 1'b1, 1'b1, 2'b11, 32'h44444444, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b0};
      tbl[11] = '{2'b00, 1'b1, 1'b1, 2'b11, 32'h55555555, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0};
      tbl[12] = '{2'b00, 1'b1, 1'b0, 2'b11, 32'h0,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1};
      tbl[13] = '{2'b00, 1'b0, 1'b0, 2'b00, 32'h0,        2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1};

      do_reset();
      #2;
      chk("reset_err", err, 1'b0);
      chk("reset_dev_req_valid", dev_req_valid, 1'b0);
      chk("reset_host_resp_valid", resp_valid, 2'b00);
      cycle_end();

      addr = {20'h00200, 20'h00010};
      wdata = {32'hAAAA5555, 32'h12345678};
      be = 8'hF3;
      wen = 2'b10;
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rv, tbl[i].drdy, tbl[i].dv, tbl[i].hrr, tbl[i].rd);
         #2;
         chk($sformatf("tbl%0d_host_req_ready", i), req_ready_o, RR ? tbl[i].rdy_rr : tbl[i].rdy_fp);
         chk($sformatf("tbl%0d_dev_req_valid", i), dev_req_valid, tbl[i].dval);
         chk($sformatf("tbl%0d_host_resp_valid", i), resp_valid, tbl[i].hval);
         chk($sformatf("tbl%0d_dev_resp_ready", i), dev_resp_ready, tbl[i].drr);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
         if (i == 0) chk("tbl0_dev_addr", dev_addr, 20'h010);
         if (i == 1) chk("tbl1_rdata", resp_rdata, 32'hDEADBEEF);
         cycle_end();
      end

      do_reset();
      gp = 0;
      for (int c = 0; c < 8; c++) begin
         g = RR ? c % 2 : 0;
         drive(2'b11, 1'b1, c > 0, 2'b11, 32'hC0DE0000 + c);
         #2;
         chk($sformatf("cont%0d_grant", c), req_ready_o, 2'(1 << g));
         if (c > 0) chk($sformatf("cont%0d_resp_route", c), resp_valid, 2'(1 << gp));
         model_check();
         cycle_end();
         gp = g;
      end
      drive(2'b00, 1'b1, 1'b1, 2'b11, 32'hC0DE00FF);
      #2;
      chk("cont_drain_route", resp_valid, 2'(1 << gp));
      model_check();
      cycle_end();

      drive(2'b00, 1'b1, 1'b1, 2'b11, 32'h0BAD0BAD);
      step();
      drive(2'b01, 1'b1, 1'b0, 2'b11, 32'h0);
      step();
      step();
      drive(2'b00, 1'b1, 1'b0, 2'b11, 32'h0);
      #2;
      model_check();
      rst_n = 1'b0;
      #1;
      chk("async_rst_err", err, 1'b0);
      dev_resp_valid = 1'b1;
      #1;
      chk("async_rst_resp_valid", resp_valid, 2'b00);
      chk("async_rst_dev_resp_ready", dev_resp_ready, 1'b1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b00, 1'b1, 1'b1, 2'b11, 32'h0FEEDF00);
      step();
      drive(2'b11, 1'b1, 1'b0, 2'b11, 32'h0);
      #2;
      chk("rr_after_reset_grant", req_ready_o, 2'b01);
      chk("stray_after_reset_err", err, 1'b1);
      model_check();
      cycle_end();

      do_reset();
      for (int c = 0; c < 400; c++) begin
         addr = {$urandom, $urandom};
         wdata = {$urandom, $urandom};
         be = 8'($urandom);
         wen = 2'($urandom);
         drive(2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 2'($urandom | $urandom), $urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
